reg_group3: RTL

Three-entry 8-bit register group; its three outputs drive the a/b/c data inputs of the CPU's 3:1 data-path selector. It sits directly upstream of that selector.
- Registers are written from the internal data bus under control-unit command.
- Each write performs one of four operations: load, increment, decrement or clear.
- Zero, carry and error status flags are registered for the control unit.

---
 rtl/reg_group3_pkg.sv | 25 ++
 rtl/reg_group3_if.sv | 33 +++
 rtl/reg_group3_reg_cell.sv | 40 ++++
 rtl/reg_group3.sv | 116 +++++++++++
 4 files changed

// File: rtl/reg_group3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_group_pkg
// Description : Shared encodings for the three-entry register group:
//               data width default, write operation codes, register addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_group_pkg;

    localparam int W_DEFAULT = 8;

    // Write operation selected by the control unit
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    // Register address; RA_NONE is an illegal target and raises err
    localparam logic [1:0] RA_R0   = 2'b00;
    localparam logic [1:0] RA_R1   = 2'b01;
    localparam logic [1:0] RA_R2   = 2'b10;
    localparam logic [1:0] RA_NONE = 2'b11;

endpackage
`default_nettype wire

// File: rtl/reg_group3_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_group3_if
// Description : Control-unit command bus and register/flag outputs of the
//               three-entry register group. master = control unit side,
//               slave = register group side.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_group3_if #(
    parameter int W = 8
);
    logic         we;
    logic [1:0]   wa;
    logic [1:0]   op;
    logic [W-1:0] d_in;
    logic [W-1:0] r0_q;
    logic [W-1:0] r1_q;
    logic [W-1:0] r2_q;
    logic         z_flag;
    logic         c_flag;
    logic         err;

    modport master (
        output we, wa, op, d_in,
        input  r0_q, r1_q, r2_q, z_flag, c_flag, err
    );

    modport slave (
        input  we, wa, op, d_in,
        output r0_q, r1_q, r2_q, z_flag, c_flag, err
    );
endinterface
`default_nettype wire

// File: rtl/reg_group3_reg_cell.sv
`default_nettype none
// ============================================================================
// Module      : reg_cell
// Description : One W-bit register with load enable and synchronous
//               active-high reset to RST_VAL.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_cell #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         en,
    input  wire logic [W-1:0] nxt,
    output logic      [W-1:0] q
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Capture the new value only when this cell is addressed
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = nxt;
        end
    end

    // Storage; reset wins over any enabled write
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule
`default_nettype wire

// File: rtl/reg_group3.sv
`default_nettype none
// ============================================================================
// Module      : reg_group3
// Description : Three 8-bit registers feeding the a/b/c inputs of the data-
//               path selector. Each write performs LOAD/INC/DEC/CLR on the
//               addressed register and updates zero/carry flags; a write to
//               address 3 produces a one-cycle err pulse instead.
//               Optional macro REG_GROUP_BYPASS_EN forwards d_in to the
//               addressed output combinationally during a LOAD.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_group3
    import reg_group_pkg::*;
#(
    parameter int           W       = W_DEFAULT,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    reg_group3_if.slave bus
);
    logic [W-1:0] cell_q [3];
    logic [2:0]   cell_en;
    logic [W-1:0] cur_val;
    logic [W:0]   alu_ext;
    logic [W-1:0] alu_res;
    logic         alu_c;
    logic         wr_valid;
    logic         wr_bad;

    logic z_flag_q, z_flag_d;
    logic c_flag_q, c_flag_d;
    logic err_q,    err_d;

    // Address decode: pick the operand and the single cell to enable
    always_comb begin
        wr_valid = bus.we && (bus.wa != RA_NONE);
        wr_bad   = bus.we && (bus.wa == RA_NONE);
        cell_en  = 3'b000;
        cur_val  = cell_q[0];
        case (bus.wa)
            RA_R0:   begin cur_val = cell_q[0]; cell_en = {2'b00, wr_valid}; end
            RA_R1:   begin cur_val = cell_q[1]; cell_en = {1'b0, wr_valid, 1'b0}; end
            RA_R2:   begin cur_val = cell_q[2]; cell_en = {wr_valid, 2'b00}; end
            default: begin cur_val = cell_q[0]; cell_en = 3'b000; end
        endcase
    end

    // Next-value ALU; one extra bit holds carry (INC) or borrow (DEC)
    always_comb begin
        alu_ext = '0;
        case (bus.op)
            OP_LOAD: alu_ext = {1'b0, bus.d_in};
            OP_INC:  alu_ext = {1'b0, cur_val} + {{W{1'b0}}, 1'b1};
            OP_DEC:  alu_ext = {1'b0, cur_val} - {{W{1'b0}}, 1'b1};
            default: alu_ext = '0;
        endcase
        alu_res = alu_ext[W-1:0];
        alu_c   = alu_ext[W] && ((bus.op == OP_INC) || (bus.op == OP_DEC));
    end

    // Flag next state: updated only by a valid write, err only by a bad one
    always_comb begin
        z_flag_d = z_flag_q;
        c_flag_d = c_flag_q;
        err_d    = wr_bad;
        if (wr_valid) begin
            z_flag_d = (alu_res == '0);
            c_flag_d = alu_c;
        end
    end

    // Flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            z_flag_q <= 1'b0;
            c_flag_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            z_flag_q <= z_flag_d;
            c_flag_q <= c_flag_d;
            err_q    <= err_d;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_cell
        reg_cell #(
            .W       (W),
            .RST_VAL (RST_VAL)
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .en  (cell_en[i]),
            .nxt (alu_res),
            .q   (cell_q[i])
        );
    end

`ifdef REG_GROUP_BYPASS_EN
    // LOAD data is forwarded to the addressed output before the edge
    logic bypass;
    assign bypass   = bus.we && (bus.op == OP_LOAD);
    assign bus.r0_q = (bypass && bus.wa == RA_R0) ? bus.d_in : cell_q[0];
    assign bus.r1_q = (bypass && bus.wa == RA_R1) ? bus.d_in : cell_q[1];
    assign bus.r2_q = (bypass && bus.wa == RA_R2) ? bus.d_in : cell_q[2];
`else
    assign bus.r0_q = cell_q[0];
    assign bus.r1_q = cell_q[1];
    assign bus.r2_q = cell_q[2];
`endif

    assign bus.z_flag = z_flag_q;
    assign bus.c_flag = c_flag_q;
    assign bus.err    = err_q;
endmodule
`default_nettype wire
